// File: rtl/counter_csr_ctrl.sv
// counter_csr_ctrl: write-port controller in front of the machine counter block.
// Arbitrates core and debug CSR writes (debug wins), owns mcountinhibit and
// splits 64-bit debug writes into two tear-free halves with the counters held.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   core_wr_req_in/addr/data core write request, core_ack_out completion pulse
//   dbg_wr_req_in/wr64/addr  debug write request (64-bit when dbg_wr64_in)
//   dbg_data_in              debug write data, dbg_ack_out completion pulse
//   dbg_halted_in            hart halted (stopcount), see macro below
//   wr_en_out/csr_addr_out/data_wr_out   counter write port
//   mcountinhibit_cy_out/_ir_out         counter inhibit inputs
//   mcountinhibit_out                    mcountinhibit read value
//
// Build option: define COUNTER_STOPCOUNT_EN to let dbg_halted_in inhibit
// both counters; otherwise dbg_halted_in is ignored.

module counter_csr_ctrl #(
    parameter logic [11:0] MCYCLE        = 12'hB00,
    parameter logic [11:0] MCYCLEH       = 12'hB80,
    parameter logic [11:0] MINSTRET      = 12'hB02,
    parameter logic [11:0] MINSTRETH     = 12'hB82,
    parameter logic [11:0] MCOUNTINHIBIT = 12'h320
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        core_wr_req_in,
    input  logic [11:0] core_addr_in,
    input  logic [31:0] core_data_in,
    output logic        core_ack_out,
    input  logic        dbg_wr_req_in,
    input  logic        dbg_wr64_in,
    input  logic [11:0] dbg_addr_in,
    input  logic [63:0] dbg_data_in,
    output logic        dbg_ack_out,
    input  logic        dbg_halted_in,
    output logic        wr_en_out,
    output logic [11:0] csr_addr_out,
    output logic [31:0] data_wr_out,
    output logic        mcountinhibit_cy_out,
    output logic        mcountinhibit_ir_out,
    output logic [31:0] mcountinhibit_out
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        WR_LO,
        WR_HI
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [11:0] hi_addr_q;
    logic [11:0] hi_addr_d;
    logic [31:0] hi_data_q;
    logic [31:0] hi_data_d;
    logic        inh_cy_q;
    logic        inh_cy_d;
    logic        inh_ir_q;
    logic        inh_ir_d;

    logic        wr_en_d;
    logic [11:0] addr_d;
    logic [31:0] data_d;
    logic        core_ack_d;
    logic        dbg_ack_d;

    logic        dbg_go;
    logic        core_go;
    logic [11:0] req_addr;
    logic [31:0] req_lo;
    logic        req_split;
    logic        forced;
    logic        halt;

`ifdef COUNTER_STOPCOUNT_EN
    assign halt = dbg_halted_in;
`else
    logic unused_halted;
    assign unused_halted = dbg_halted_in;
    assign halt          = 1'b0;
`endif

    // Grant selection: debug always beats core in IDLE.
    always_comb begin
        dbg_go    = (state_q == IDLE) && dbg_wr_req_in;
        core_go   = (state_q == IDLE) && !dbg_wr_req_in && core_wr_req_in;
        req_addr  = dbg_go ? dbg_addr_in : core_addr_in;
        req_lo    = dbg_go ? dbg_data_in[31:0] : core_data_in;
        req_split = dbg_go && dbg_wr64_in &&
                    ((dbg_addr_in == MCYCLE) || (dbg_addr_in == MINSTRET));
    end

    // Outputs are computed one step ahead and registered below, so the
    // values chosen here appear during the cycle that follows.
    always_comb begin
        state_d    = state_q;
        hi_addr_d  = hi_addr_q;
        hi_data_d  = hi_data_q;
        inh_cy_d   = inh_cy_q;
        inh_ir_d   = inh_ir_q;
        wr_en_d    = 1'b0;
        addr_d     = '0;
        data_d     = '0;
        core_ack_d = 1'b0;
        dbg_ack_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dbg_go || core_go) begin
                    if (req_addr == MCOUNTINHIBIT) begin
                        inh_cy_d   = req_lo[0];
                        inh_ir_d   = req_lo[2];
                        state_d    = WR;
                        core_ack_d = core_go;
                        dbg_ack_d  = dbg_go;
                    end else if (req_split) begin
                        state_d   = WR_LO;
                        wr_en_d   = 1'b1;
                        addr_d    = req_addr;
                        data_d    = req_lo;
                        hi_addr_d = (req_addr == MCYCLE) ? MCYCLEH : MINSTRETH;
                        hi_data_d = dbg_data_in[63:32];
                    end else begin
                        state_d    = WR;
                        wr_en_d    = 1'b1;
                        addr_d     = req_addr;
                        data_d     = req_lo;
                        core_ack_d = core_go;
                        dbg_ack_d  = dbg_go;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            WR_LO: begin
                state_d   = WR_HI;
                wr_en_d   = 1'b1;
                addr_d    = hi_addr_q;
                data_d    = hi_data_q;
                dbg_ack_d = 1'b1;
            end
            WR_HI: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hold both counters for the whole split write so no increment lands
    // between the halves.
    assign forced = (state_d == WR_LO) || (state_d == WR_HI);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q              <= IDLE;
            hi_addr_q            <= '0;
            hi_data_q            <= '0;
            inh_cy_q             <= 1'b0;
            inh_ir_q             <= 1'b0;
            wr_en_out            <= 1'b0;
            csr_addr_out         <= '0;
            data_wr_out          <= '0;
            core_ack_out         <= 1'b0;
            dbg_ack_out          <= 1'b0;
            mcountinhibit_cy_out <= 1'b0;
            mcountinhibit_ir_out <= 1'b0;
            mcountinhibit_out    <= '0;
        end else begin
            state_q              <= state_d;
            hi_addr_q            <= hi_addr_d;
            hi_data_q            <= hi_data_d;
            inh_cy_q             <= inh_cy_d;
            inh_ir_q             <= inh_ir_d;
            wr_en_out            <= wr_en_d;
            csr_addr_out         <= addr_d;
            data_wr_out          <= data_d;
            core_ack_out         <= core_ack_d;
            dbg_ack_out          <= dbg_ack_d;
            mcountinhibit_cy_out <= inh_cy_q | forced | halt;
            mcountinhibit_ir_out <= inh_ir_q | forced | halt;
            mcountinhibit_out    <= {29'b0, inh_ir_q, 1'b0, inh_cy_q};
        end
    end

endmodule

// File: doc/counter_csr_ctrl.md
# counter_csr_ctrl

Write-port controller in front of the machine counter block. Arbitrates CSR write requests from the core pipeline and the debug module onto the counter's single write port (`csr_addr`/`data_wr`/`wr_en`). Owns the `mcountinhibit` CSR and drives the counter's cycle and instret inhibit inputs. Sequences 64-bit debug writes as two tear-free 32-bit halves.

## Interface
**Parameters** (name, default, meaning):
- `MCYCLE`, 12'hB00, cycle counter low address
- `MCYCLEH`, 12'hB80, cycle counter high address
- `MINSTRET`, 12'hB02, instret counter low address
- `MINSTRETH`, 12'hB82, instret counter high address
- `MCOUNTINHIBIT`, 12'h320, inhibit CSR address

**Ports** (name, direction, width, meaning):
- `clk_in` input 1: single clock
- `rst_in` input 1: synchronous reset, active-high
- `core_wr_req_in` input 1: core write request
- `core_addr_in` input 12: core CSR address
- `core_data_in` input 32: core write data
- `core_ack_out` output 1: one-cycle completion pulse to core
- `dbg_wr_req_in` input 1: debug write request
- `dbg_wr64_in` input 1: debug request is a 64-bit write
- `dbg_addr_in` input 12: debug CSR address (low-half address for 64-bit writes)
- `dbg_data_in` input 64: debug write data
- `dbg_ack_out` output 1: one-cycle completion pulse to debug
- `dbg_halted_in` input 1: hart halted in debug mode (stopcount)
- `wr_en_out` output 1: counter write enable
- `csr_addr_out` output 12: counter CSR address
- `data_wr_out` output 32: counter write data
- `mcountinhibit_cy_out` output 1: cycle counter inhibit
- `mcountinhibit_ir_out` output 1: instret counter inhibit
- `mcountinhibit_out` output 32: `mcountinhibit` read value

## Operation
- FSM states: IDLE, WR, WR_LO, WR_HI. All outputs registered.
- IDLE arbitration is fixed priority: debug over core. The loser is not acked and must keep its request asserted.
- A granted request latches its address and data.
  - Address `MCOUNTINHIBIT`: update the inhibit register bits 0 (CY) and 2 (IR) from data bits 0 and 2. Other bits read 0. `wr_en_out` stays 0. Go to WR, which issues the ack.
  - Any other address, 32-bit: go to WR and drive `wr_en_out`=1 with the latched address and data[31:0]. Addresses outside the counter map are forwarded unchanged; the counter ignores them.
  - Debug 64-bit with `dbg_addr_in` equal to `MCYCLE` or `MINSTRET`: go to WR_LO, then WR_HI.
    - WR_LO drives the low address with data[31:0].
    - WR_HI drives the matching high address (`MCYCLEH`/`MINSTRETH`) with data[63:32].
  - Debug 64-bit to any other address: treated as a 32-bit write of data[31:0].
- WR and WR_HI return to IDLE on the next cycle.
- Inhibit outputs:
  - `cy` = reg[0] OR forced. `ir` = reg[2] OR forced.
  - Forced is asserted in both WR_LO and WR_HI, so the counter loads the exact 64-bit value with no +1 between halves.
- `mcountinhibit_out` = {29'b0, reg[2], 1'b0, reg[0]}.

## Timing
- Request sampled in IDLE at cycle N.
- 32-bit write or inhibit write: `wr_en_out`/`ack` high in N+1. FSM is in IDLE at N+2 and may grant again at N+2.
- 64-bit write:
  - low half in N+1, high half plus ack in N+2, forced inhibit in N+1 and N+2.
  - Counter reads exactly `dbg_data_in` at N+3 and increments from N+3.
- Requesters must drop or change their request in the cycle after ack. A request still held at that point is a new request.
- Inhibit register change is visible on the inhibit outputs in N+2 (cycle after the WR cycle).
- Reset values: state IDLE, inhibit register 0, all outputs 0 (`csr_addr_out`=0, `data_wr_out`=0, both acks 0, both inhibits 0).
- Reset during WR_LO/WR_HI aborts the sequence: no ack, high half not written, inhibits 0 the next cycle.
- Simultaneous core and debug requests in IDLE: debug served first. Core is granted at the first IDLE with no debug request.

## Configuration
- `COUNTER_STOPCOUNT_EN` defined: `dbg_halted_in`=1 ORs into both inhibit outputs, combined with the register. Applies one cycle after it is sampled. `mcountinhibit_out` is unaffected.
- Not defined: `dbg_halted_in` is ignored. The port remains present.

## Test plan
- Reset, then core writes 0x0000_0010 to 0xB00 → `wr_en_out`=1, `csr_addr_out`=0xB00, `data_wr_out`=0x10, `core_ack_out` pulse, all one cycle after request.
- Debug 64-bit write of 0x0000_0001_FFFF_FFF0 to 0xB00 → 0xB00/0xFFFF_FFF0 then 0xB80/0x0000_0001 with `cy` inhibit high both cycles. Counter reads 0x0000_0001_FFFF_FFF0, then 0x...FFF1 the next cycle. `dbg_ack_out` pulses once, with the high half.
- Core and debug request in the same cycle → debug is acked first and the core ack follows two cycles later; no requests are lost.
- Core writes 0x5 to 0x320 → `wr_en_out` stays 0, `mcountinhibit_out`=0x5, both inhibits high. Writing 0x0 clears them.
- Reset asserted during WR_LO of a 64-bit write → no `dbg_ack_out`, no 0xB80 write, outputs return to reset values.
- With `COUNTER_STOPCOUNT_EN`: `dbg_halted_in`=1 → both inhibits high with `mcountinhibit_out`=0. Without the macro, the inhibits stay 0.
